// File: rtl/xor4_pc_pkg.sv
// Shared types and constants for the 4-bit parity checker.
// Optional build macro XOR4_PC_DROP_EN is consumed by xor4_parity_checker.
package xor4_pc_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              perr;
    } entry_t;

    // Largest value a w-bit saturating counter may hold.
    function automatic int unsigned sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/xor4_pc_fifo2.sv
// Two-entry valid/ready FIFO of entry_t with registered ready/valid flags.
// Slot 0 is always the head; slot 1 holds the second word when full.
module xor4_pc_fifo2
    import xor4_pc_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   in_valid_i,
    output logic   in_ready_o,
    input  entry_t in_data_i,
    output logic   out_valid_o,
    input  logic   out_ready_i,
    output entry_t out_data_o
);

    localparam logic [1:0] Full = 2'(DEPTH);

    logic [1:0] occ_q, occ_d;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic       ovld_q, ovld_d;
    logic       irdy_q, irdy_d;
    logic       push, pop;

    assign push = in_valid_i & irdy_q;
    assign pop  = ovld_q & out_ready_i;

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (occ_q)
            2'd0: begin
                if (push) begin
                    slot0_d = in_data_i;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                // Simultaneous push and pop replaces the head in place.
                if (push && pop) begin
                    slot0_d = in_data_i;
                end else if (push) begin
                    slot1_d = in_data_i;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    occ_d   = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
        ovld_d = (occ_d != 2'd0);
        irdy_d = (occ_d != Full);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            ovld_q  <= 1'b0;
            irdy_q  <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            ovld_q  <= ovld_d;
            irdy_q  <= irdy_d;
        end
    end

    assign in_ready_o  = irdy_q;
    assign out_valid_o = ovld_q;
    assign out_data_o  = slot0_q;

endmodule

// File: rtl/xor4_parity_checker.sv
// Receive-side parity checker: buffers each nibble with its error flag, counts bad words.
// Define XOR4_PC_DROP_EN to swallow bad words instead of forwarding them.
module xor4_parity_checker
    import xor4_pc_pkg::*;
#(
    parameter bit          ODD   = 1'b0,
    parameter int unsigned CNT_W = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              A,
    input  logic              B,
    input  logic              C,
    input  logic              D,
    input  logic              P,
    input  logic              IVLD,
    output logic              IRDY,
    output logic [DATA_W-1:0] DOUT,
    output logic              PERR,
    output logic              OVLD,
    input  logic              ORDY,
    input  logic              CLR,
    output logic [CNT_W-1:0]  ERRCNT,
    output logic              ERRSTK
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

    logic             bad;
    logic             accept;
    logic             fifo_wr;
    entry_t           wr_entry;
    entry_t           head;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stk_q, stk_d;

    assign bad    = (^{A, B, C, D, P}) ^ ODD;
    assign accept = IVLD & IRDY;

`ifdef XOR4_PC_DROP_EN
    // Bad words still complete the handshake but never reach the buffer.
    assign fifo_wr       = IVLD & ~bad;
    assign wr_entry.perr = 1'b0;
`else
    assign fifo_wr       = IVLD;
    assign wr_entry.perr = bad;
`endif
    assign wr_entry.d = {A, B, C, D};

    xor4_pc_fifo2 u_fifo (
        .clk_i       (CK),
        .rst_ni      (RSTN),
        .in_valid_i  (fifo_wr),
        .in_ready_o  (IRDY),
        .in_data_i   (wr_entry),
        .out_valid_o (OVLD),
        .out_ready_i (ORDY),
        .out_data_o  (head)
    );

    assign DOUT = head.d;
`ifdef XOR4_PC_DROP_EN
    assign PERR = 1'b0;
`else
    assign PERR = head.perr;
`endif

    // CLR takes effect before a coincident bad word is counted.
    always_comb begin
        cnt_d = CLR ? '0 : cnt_q;
        stk_d = CLR ? 1'b0 : stk_q;
        if (accept && bad) begin
            if (cnt_d != CntMax) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
            stk_d = 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            cnt_q <= '0;
            stk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stk_q <= stk_d;
        end
    end

    assign ERRCNT = cnt_q;
    assign ERRSTK = stk_q;

endmodule

// File: tb/tb_xor4_parity_checker.sv
// Bench for xor4_parity_checker: vector table, directed corner sequences, random vs queue model.
// Honours XOR4_PC_DROP_EN when the design is built with it.
module tb_xor4_parity_checker;

    logic       ck;
    logic       rstn;
    logic [3:0] din;
    logic       p;
    logic       ivld;
    logic       ordy;
    logic       clr;

    logic       irdy_e, perr_e, ovld_e, errstk_e;
    logic [3:0] dout_e;
    logic [1:0] errcnt_e;
    logic       irdy_o, perr_o, ovld_o, errstk_o;
    logic [3:0] dout_o;
    logic [7:0] errcnt_o;

    int n_total;
    int n_bad;

    xor4_parity_checker #(.ODD(1'b0), .CNT_W(2)) u_even (
        .CK(ck), .RSTN(rstn), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]), .P(p),
        .IVLD(ivld), .IRDY(irdy_e), .DOUT(dout_e), .PERR(perr_e), .OVLD(ovld_e),
        .ORDY(ordy), .CLR(clr), .ERRCNT(errcnt_e), .ERRSTK(errstk_e)
    );

    xor4_parity_checker #(.ODD(1'b1), .CNT_W(8)) u_odd (
        .CK(ck), .RSTN(rstn), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]), .P(p),
        .IVLD(ivld), .IRDY(irdy_o), .DOUT(dout_o), .PERR(perr_o), .OVLD(ovld_o),
        .ORDY(ordy), .CLR(clr), .ERRCNT(errcnt_o), .ERRSTK(errstk_o)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model: one queue per instance holding {data, raw 5-bit xor}.
    typedef struct packed {
        logic [3:0] d;
        logic       x;
    } went_t;

    went_t eq[$];
    went_t oq[$];
    int    e_cnt, o_cnt;
    bit    e_stk, o_stk;

    function automatic bit keep_word(input bit x, input bit odd);
`ifdef XOR4_PC_DROP_EN
        return (x ^ odd) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_perr(input bit x, input bit odd);
`ifdef XOR4_PC_DROP_EN
        return 1'b0;
`else
        return x ^ odd;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        bit x, acc_e, acc_o, pop_e, pop_o;
        x     = ^{din, p};
        acc_e = ivld && (eq.size() < 2);
        acc_o = ivld && (oq.size() < 2);
        pop_e = ordy && (eq.size() > 0);
        pop_o = ordy && (oq.size() > 0);
        @(posedge ck);
        if (!rstn) begin
            eq.delete();
            oq.delete();
            e_cnt = 0;
            o_cnt = 0;
            e_stk = 0;
            o_stk = 0;
        end else begin
            if (pop_e) void'(eq.pop_front());
            if (pop_o) void'(oq.pop_front());
            if (acc_e && keep_word(x, 1'b0)) eq.push_back('{d: din, x: x});
            if (acc_o && keep_word(x, 1'b1)) oq.push_back('{d: din, x: x});
            if (clr) begin
                e_cnt = 0;
                o_cnt = 0;
                e_stk = 0;
                o_stk = 0;
            end
            if (acc_e && x) begin
                e_cnt = (e_cnt >= 3) ? 3 : e_cnt + 1;
                e_stk = 1;
            end
            if (acc_o && !x) begin
                o_cnt = (o_cnt >= 255) ? 255 : o_cnt + 1;
                o_stk = 1;
            end
        end
        #1;
    endtask

    task automatic check_model();
        chk("m_ovld_e", ovld_e, eq.size() > 0);
        chk("m_irdy_e", irdy_e, eq.size() < 2);
        if (eq.size() > 0) begin
            chk("m_dout_e", dout_e, eq[0].d);
            chk("m_perr_e", perr_e, exp_perr(eq[0].x, 1'b0));
        end
        chk("m_errcnt_e", errcnt_e, e_cnt);
        chk("m_errstk_e", errstk_e, e_stk);
        chk("m_ovld_o", ovld_o, oq.size() > 0);
        chk("m_irdy_o", irdy_o, oq.size() < 2);
        if (oq.size() > 0) begin
            chk("m_dout_o", dout_o, oq[0].d);
            chk("m_perr_o", perr_o, exp_perr(oq[0].x, 1'b1));
        end
        chk("m_errcnt_o", errcnt_o, o_cnt);
        chk("m_errstk_o", errstk_o, o_stk);
    endtask

    typedef struct {
        logic [3:0] w;
        logic       p;
        logic [3:0] e_dout;
        logic       e_perr;
        logic [1:0] e_cnt;
        logic       e_stk;
    } vec_t;

    vec_t tbl[8];

    initial begin
        n_total = 0;
        n_bad   = 0;
        e_cnt   = 0;
        o_cnt   = 0;
        e_stk   = 0;
        o_stk   = 0;

        // Streaming with ORDY=1: each word is on DOUT one edge after its accept.
        tbl[0] = '{4'hB, 1'b1, 4'hB, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'h3, 1'b1, 4'h3, 1'b1, 2'd1, 1'b1};
        tbl[2] = '{4'h7, 1'b1, 4'h7, 1'b0, 2'd1, 1'b1};
        tbl[3] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        tbl[4] = '{4'hF, 1'b1, 4'hF, 1'b1, 2'd2, 1'b1};
        tbl[5] = '{4'h8, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1};
        tbl[6] = '{4'h6, 1'b1, 4'h6, 1'b1, 2'd3, 1'b1};
        tbl[7] = '{4'hA, 1'b0, 4'hA, 1'b0, 2'd3, 1'b1};

        rstn = 1'b0;
        ivld = 1'b0;
        ordy = 1'b0;
        clr  = 1'b0;
        din  = 4'h0;
        p    = 1'b0;
        @(negedge ck);
        step();
        step();
        chk("rst_ovld", ovld_e, 1'b0);
        chk("rst_irdy", irdy_e, 1'b1);
        chk("rst_dout", dout_e, 4'h0);
        chk("rst_perr", perr_e, 1'b0);
        chk("rst_errcnt", errcnt_e, 2'd0);
        chk("rst_errstk", errstk_e, 1'b0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            din  = tbl[i].w;
            p    = tbl[i].p;
            ivld = 1'b1;
            ordy = 1'b1;
            step();
            check_model();
`ifndef XOR4_PC_DROP_EN
            chk($sformatf("tbl%0d_ovld", i), ovld_e, 1'b1);
            chk($sformatf("tbl%0d_dout", i), dout_e, tbl[i].e_dout);
            chk($sformatf("tbl%0d_perr", i), perr_e, tbl[i].e_perr);
`endif
            chk($sformatf("tbl%0d_errcnt", i), errcnt_e, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_errstk", i), errstk_e, tbl[i].e_stk);
        end

        // Drain, then fill with ORDY low and confirm back-pressure and order.
        ivld = 1'b0;
        step();
        check_model();
        chk("drain_ovld", ovld_e, 1'b0);
        ordy = 1'b0;
        ivld = 1'b1;
        din  = 4'h1;
        p    = 1'b1;
        step();
        check_model();
        din = 4'h2;
        p   = 1'b1;
        step();
        check_model();
        chk("full_irdy", irdy_e, 1'b0);
        din = 4'h9;
        p   = 1'b0;
        step();
        check_model();
        chk("full_ignore_dout", dout_e, 4'h1);
        chk("full_ignore_irdy", irdy_e, 1'b0);
        ivld = 1'b0;
        ordy = 1'b1;
        step();
        check_model();
        chk("pop1_dout", dout_e, 4'h2);
        chk("pop1_irdy", irdy_e, 1'b1);
        step();
        check_model();
        chk("pop2_ovld", ovld_e, 1'b0);

        // CLR coinciding with a bad word: cleared first, then counted.
        ivld = 1'b1;
        din  = 4'h3;
        p    = 1'b1;
        clr  = 1'b1;
        step();
        check_model();
        chk("clrbad_errcnt", errcnt_e, 2'd1);
        chk("clrbad_errstk", errstk_e, 1'b1);
        ivld = 1'b0;
        step();
        check_model();
        chk("clr_errcnt", errcnt_e, 2'd0);
        chk("clr_errstk", errstk_e, 1'b0);
        clr = 1'b0;

        // Occupancy 1 with push and pop together: new word becomes head.
        ordy = 1'b0;
        ivld = 1'b1;
        din  = 4'h4;
        p    = 1'b1;
        step();
        check_model();
        ordy = 1'b1;
        din  = 4'h5;
        p    = 1'b0;
        step();
        check_model();
        chk("pushpop_dout", dout_e, 4'h5);
        chk("pushpop_ovld", ovld_e, 1'b1);
        chk("pushpop_irdy", irdy_e, 1'b1);
        ivld = 1'b0;
        step();
        check_model();
        chk("pushpop_occ1", ovld_e, 1'b0);

        // Reset while holding words and a set sticky flag.
        ordy = 1'b0;
        ivld = 1'b1;
        din  = 4'h3;
        p    = 1'b1;
        step();
        check_model();
        din = 4'h6;
        p   = 1'b0;
        step();
        check_model();
        chk("prerst_errstk", errstk_e, 1'b1);
        rstn = 1'b0;
        ivld = 1'b0;
        step();
        check_model();
        chk("midrst_ovld", ovld_e, 1'b0);
        chk("midrst_irdy", irdy_e, 1'b1);
        chk("midrst_errcnt", errcnt_e, 2'd0);
        chk("midrst_errstk", errstk_e, 1'b0);
        rstn = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            ivld = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            rstn = ($urandom_range(0, 199) != 0);
            din  = 4'($urandom);
            p    = 1'($urandom);
            step();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
